// File: rtl/zmod_adc_axis_packer.sv
// rtl/zmod_adc_axis_packer.sv - packs Zmod ADC sample pairs into 32-bit stream beats with run framing
// Optional: ZMOD_PACKER_TEST_PATTERN_EN adds test_mode and a ramp test pattern source.
module zmod_adc_axis_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        adc_valid,
    input  logic [13:0] ch1_data,
    input  logic [13:0] ch2_data,
`ifdef ZMOD_PACKER_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic        m0_tready,
    output logic        m0_tvalid,
    output logic [31:0] m0_tdata,
    output logic        m0_tlast,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] NEAR_FULL = (AW + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic        hold_valid;
    logic [31:0] hold_data;

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        empty;
    logic        pop;
    logic        run_start;
    logic        sample_take;
    logic        stop;
    logic        push_try;
    logic        refuse;
    logic        push;
    logic [32:0] push_word;
    logic [13:0] cap_ch1;
    logic [13:0] cap_ch2;
    logic [31:0] packed_pair;

    assign empty       = (count == '0);
    assign pop         = !empty && m0_tready;
    assign run_start   = (state == ST_IDLE) && enable;
    assign sample_take = (state == ST_RUN) && enable && adc_valid;
    assign stop        = (state == ST_RUN) && !enable;

    // A displaced hold entry may only use the FIFO while a slot remains free for the tlast beat.
    assign push_try  = sample_take && hold_valid;
    assign refuse    = push_try && (count >= NEAR_FULL) && !pop;
    assign push      = (push_try && !refuse) || (stop && hold_valid);
    assign push_word = {stop, hold_data};

`ifdef ZMOD_PACKER_TEST_PATTERN_EN
    logic [13:0] ramp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ramp <= '0;
        end else if (run_start) begin
            ramp <= '0;
        end else if (sample_take) begin
            ramp <= ramp + 14'd1;
        end
    end

    assign cap_ch1 = test_mode ? ramp  : ch1_data;
    assign cap_ch2 = test_mode ? ~ramp : ch2_data;
`else
    assign cap_ch1 = ch1_data;
    assign cap_ch2 = ch2_data;
`endif

    assign packed_pair = {cap_ch1, 2'b00, cap_ch2, 2'b00};

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable) state_next = ST_RUN;
            ST_RUN:   if (!enable) state_next = ST_DRAIN;
            ST_DRAIN: if (empty) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (run_start) begin
                overflow <= 1'b0;
            end else if (refuse) begin
                overflow <= 1'b1;
            end
            if (sample_take) begin
                hold_valid <= 1'b1;
                hold_data  <= packed_pair;
            end else if (stop) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the outputs are gated by the occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    assign m0_tvalid = !empty;
    assign m0_tdata  = empty ? 32'd0 : mem[rd_ptr][31:0];
    assign m0_tlast  = empty ? 1'b0  : mem[rd_ptr][32];
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_zmod_adc_axis_packer.sv
// tb/tb_zmod_adc_axis_packer.sv - scoreboard bench for zmod_adc_axis_packer
module tb_zmod_adc_axis_packer;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic [13:0] ch1_data = '0;
    logic [13:0] ch2_data = '0;
    logic        m0_tready = 1'b0;
    logic        m0_tvalid;
    logic [31:0] m0_tdata;
    logic        m0_tlast;
    logic        busy;
    logic        overflow;
`ifdef ZMOD_PACKER_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    zmod_adc_axis_packer #(.FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .adc_valid (adc_valid),
        .ch1_data  (ch1_data),
        .ch2_data  (ch2_data),
`ifdef ZMOD_PACKER_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .m0_tready (m0_tready),
        .m0_tvalid (m0_tvalid),
        .m0_tdata  (m0_tdata),
        .m0_tlast  (m0_tlast),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: run state, hold slot, and queue of beats expected on m0.
    logic [32:0] exp_q[$];
    logic [31:0] got_q[$];
    int          m_st = 0;
    logic        m_hv = 1'b0;
    logic [31:0] m_hd = '0;
    logic        m_ovf = 1'b0;
    bit          pend = 0;
    bit          pend_clear = 0;
    logic        exp_busy = 1'b0;
    logic        exp_ovf = 1'b0;
    bit          chk_en = 0;
    int          beats_seen = 0;
    int          last_seen = 0;
    int          committed;

    function automatic logic [31:0] pack(input logic [13:0] c1, input logic [13:0] c2);
        return {c1, 2'b00, c2, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic v, input logic [13:0] c1,
                        input logic [13:0] c2, input logic rdy, input logic rn);
        int  sz;
        bit  will_pop;
        @(posedge clk);
        #1;
        exp_busy  = (m_st != 0);
        exp_ovf   = m_ovf;
        enable    = en;
        adc_valid = v;
        ch1_data  = c1;
        ch2_data  = c2;
        m0_tready = rdy;
        resetn    = rn;
        sz        = exp_q.size();
        will_pop  = rdy && (sz > 0);
        if (!rn) begin
            m_st = 0;
            m_hv = 1'b0;
            m_ovf = 1'b0;
            pend_clear = 1;
        end else begin
            case (m_st)
                0: if (en) begin
                    m_st = 1;
                    m_ovf = 1'b0;
                end
                1: if (en) begin
                    if (v) begin
                        if (m_hv) begin
                            if (sz >= D - 1 && !will_pop) begin
                                m_ovf = 1'b1;
                            end else begin
                                exp_q.push_back({1'b0, m_hd});
                                pend = 1;
                            end
                        end
                        m_hd = pack(c1, c2);
                        m_hv = 1'b1;
                    end
                end else begin
                    if (m_hv) begin
                        exp_q.push_back({1'b1, m_hd});
                        pend = 1;
                    end
                    m_hv = 1'b0;
                    m_st = 2;
                end
                default: if (sz == 0) m_st = 0;
            endcase
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 14'd0, 14'd0, rdy, 1'b1);
    endtask

    task automatic drain(input int thr);
        int n = 0;
        while ((m_st != 0 || exp_q.size() != 0) && n < 400) begin
            idle(1'($urandom_range(0, 99) < thr));
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: model still busy after %0d cycles", n);
        end
        idle(1'b1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            committed = exp_q.size() - (pend ? 1 : 0);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
            chk("tvalid", 64'(m0_tvalid), 64'(committed > 0));
            if (m0_tvalid && committed > 0) begin
                chk("tdata", 64'(m0_tdata), 64'(exp_q[0][31:0]));
                chk("tlast", 64'(m0_tlast), 64'(exp_q[0][32]));
                if (m0_tready) begin
                    got_q.push_back(m0_tdata);
                    beats_seen++;
                    if (m0_tlast) last_seen++;
                    void'(exp_q.pop_front());
                end
            end
            pend = 0;
            if (pend_clear) begin
                exp_q.delete();
                pend_clear = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int l0;
        int g0;
        int thr;
        int len;

        step(1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0);
        chk_en = 1;
        step(1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0);
        chk("reset_tdata", 64'(m0_tdata), 64'd0);
        chk("reset_tlast", 64'(m0_tlast), 64'd0);
        idle(1'b1);

        // Continuous run of 5 pairs.
        b0 = beats_seen; l0 = last_seen; g0 = got_q.size();
        step(1'b1, 1'b0, 14'd0, 14'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 14'(i), 14'h3FFF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 14'h55, 14'h55, 1'b1, 1'b1);
        drain(100);
        chk("cont_beats", 64'(beats_seen - b0), 64'd5);
        chk("cont_last", 64'(last_seen - l0), 64'd1);
        if (got_q.size() > g0) chk("cont_first", 64'(got_q[g0]), 64'h0004FFFC);
        else chk("cont_first_missing", 64'(got_q.size()), 64'(g0 + 1));

        // Backpressure with ready pattern 1,0,0,1.
        b0 = beats_seen;
        step(1'b1, 1'b0, 14'd0, 14'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 14'(i), 14'h3FFF, (i % 4) == 0 || (i % 4) == 1, 1'b1);
        step(1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) idle((i % 4) == 0 || (i % 4) == 3);
        drain(100);
        chk("bp_beats", 64'(beats_seen - b0), 64'd5);

        // Overflow: 40 pairs against a stalled sink.
        b0 = beats_seen; l0 = last_seen; g0 = got_q.size();
        step(1'b1, 1'b0, 14'd0, 14'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++) step(1'b1, 1'b1, 14'(i), 14'(i), 1'b0, 1'b1);
        step(1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b1);
        idle(1'b0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        drain(100);
        chk("ovf_beats", 64'(beats_seen - b0), 64'd16);
        chk("ovf_last", 64'(last_seen - l0), 64'd1);
        if (got_q.size() >= g0 + 16) begin
            chk("ovf_beat15", 64'(got_q[g0 + 14]), 64'(pack(14'd15, 14'd15)));
            chk("ovf_beat16", 64'(got_q[g0 + 15]), 64'(pack(14'd40, 14'd40)));
        end
        step(1'b1, 1'b0, 14'd0, 14'd0, 1'b1, 1'b1);
        idle(1'b1);
        chk("ovf_cleared", 64'(overflow), 64'd0);
        drain(100);

        // Empty run.
        b0 = beats_seen;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 14'h1234, 14'h0321, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("empty_idle", 64'(busy), 64'd0);
        chk("empty_beats", 64'(beats_seen - b0), 64'd0);

        // Reset with 6 beats buffered.
        l0 = last_seen;
        step(1'b1, 1'b0, 14'd0, 14'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b1, 14'(i + 100), 14'(i), 1'b0, 1'b1);
        step(1'b1, 1'b1, 14'd9, 14'd9, 1'b0, 1'b0);
        idle(1'b1);
        chk("rst_tvalid", 64'(m0_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("rst_no_last", 64'(last_seen - l0), 64'd0);

        // Randomized runs with varying backpressure.
        for (int r = 0; r < 12; r++) begin
            thr = $urandom_range(0, 100);
            len = $urandom_range(3, 70);
            step(1'b1, 1'b0, 14'd0, 14'd0, 1'b0, 1'b1);
            for (int i = 0; i < len; i++)
                step(1'b1, 1'($urandom_range(0, 3) != 0), 14'($urandom), 14'($urandom),
                     1'($urandom_range(0, 99) < thr), 1'b1);
            step(1'b0, 1'($urandom), 14'($urandom), 14'($urandom), 1'($urandom_range(0, 99) < thr), 1'b1);
            drain(thr < 20 ? 50 : thr);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
